// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule state type and the small sigma functions.
// The compression core reuses the sigma helpers alongside its own big-sigma logic.
package sha256_pkg;

  localparam int BLOCK_BYTES  = 64;
  localparam int WINDOW_WORDS = 16;
  localparam int ROUNDS       = 64;

  typedef enum logic {
    SCHED_COLLECT = 1'b0,
    SCHED_EMIT    = 1'b1
  } sched_state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: packs 64 streamed bytes into a 16-word window, then
// emits W0..W63 one per handshake, expanding the window in place with the sigma recurrence.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] w_out,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [5:0]  w_index,
  output logic        sched_done,
  output logic        byte_drop
);

  localparam logic [5:0] LAST_BYTE  = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  sched_state_t state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [5:0]   t_q, t_d;
  logic [31:0]  win_q [WINDOW_WORDS];
  logic [31:0]  win_d [WINDOW_WORDS];
  logic         done_q, done_d;
  logic         drop_q, drop_d;
  logic [31:0]  w_next;

  // W[t+16] from the window holding W[t..t+15]; additions wrap at 32 bits.
  assign w_next = win_q[0] + small_sigma0(win_q[1]) + win_q[9] + small_sigma1(win_q[14]);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    win_d   = win_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      SCHED_COLLECT: begin
        if (byte_valid) begin
          // The window acts as one 512-bit big-endian shift register: byte 0 ends in win[0][31:24].
          for (int i = 0; i < WINDOW_WORDS - 1; i++) begin
            win_d[i] = {win_q[i][23:0], win_q[i+1][31:24]};
          end
          win_d[WINDOW_WORDS-1] = {win_q[WINDOW_WORDS-1][23:0], byte_in};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_BYTE) begin
            state_d = SCHED_EMIT;
            t_d     = '0;
          end
        end
      end
      SCHED_EMIT: begin
        drop_d = byte_valid;
        if (w_ready) begin
          for (int i = 0; i < WINDOW_WORDS - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[WINDOW_WORDS-1] = w_next;
          t_d = t_q + 6'd1;
          if (t_q == LAST_ROUND) begin
            state_d = SCHED_COLLECT;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = SCHED_COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCHED_COLLECT;
      cnt_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      // NOTE: the window is a flop array, not a RAM, so it can and must clear on reset.
      for (int i = 0; i < WINDOW_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      win_q   <= win_d;
    end
  end

  assign w_valid    = (state_q == SCHED_EMIT);
  assign w_out      = w_valid ? win_q[0] : '0;
  assign w_index    = t_q;
  assign sched_done = done_q;
  assign byte_drop  = drop_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: directed "abc" blocks plus random
// blocks, compared against a FIPS 180-4 style array model of the message schedule.
module tb_sha256_msg_schedule;

  typedef logic [7:0]  blk_t   [64];
  typedef logic [31:0] sched_t [64];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [31:0] w_out;
  logic        w_valid;
  logic        w_ready;
  logic [5:0]  w_index;
  logic        sched_done;
  logic        byte_drop;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  logic [31:0] got_w [64];

  sha256_msg_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .w_out      (w_out),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_index    (w_index),
    .sched_done (sched_done),
    .byte_drop  (byte_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sched_done) done_cnt++;
    if (byte_drop)  drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: textbook schedule over a plain array.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t ref_schedule(input blk_t b);
    sched_t w;
    for (int t = 0; t < 16; t++)
      w[t] = {b[4*t], b[4*t+1], b[4*t+2], b[4*t+3]};
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    return w;
  endfunction

  function automatic blk_t abc_block();
    blk_t b;
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    b[0] = 8'h61; b[1] = 8'h62; b[2] = 8'h63; b[3] = 8'h80; b[63] = 8'h18;
    return b;
  endfunction

  // Inputs change right after a negedge; outputs are sampled at negedges.
  task automatic send_block(input blk_t b, input int gap);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("no_early_valid", {31'b0, w_valid}, 32'd0);
      byte_valid = 1'b1;
      byte_in    = b[i];
      w_ready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      byte_valid = 1'b0;
      if (i < 63) repeat (gap) @(negedge clk);
    end
  endtask

  // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready.
  task automatic receive_block(input sched_t exp, input int mode, input bit inject_drops);
    int t = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit did_t10 = 1'b0;
    logic prev_bv = 1'b0;
    logic rdy, bv;
    logic [31:0] prev_w;
    logic [5:0]  prev_i;
    prev_w = '0;
    prev_i = '0;
    while (t < 64) begin
      if (cyc >= 400) begin
        check("emit_timeout", 32'd0, 32'd1);
        break;
      end
      check("byte_drop", {31'b0, byte_drop}, {31'b0, prev_bv});
      check("w_valid", {31'b0, w_valid}, 32'd1);
      if (stalled) begin
        check("stall_w_out", w_out, prev_w);
        check("stall_w_index", {26'b0, w_index}, {26'b0, prev_i});
      end
      check("w_index", {26'b0, w_index}, 32'(t));
      check($sformatf("W%0d", t), w_out, exp[t]);
      got_w[t] = w_out;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bv = 1'b0;
      if (inject_drops && t == 10 && !did_t10) begin
        bv = 1'b1;
        did_t10 = 1'b1;
      end
      if (inject_drops && t == 63 && rdy) bv = 1'b1;
      byte_valid = bv;
      byte_in    = 8'($urandom);
      w_ready    = rdy;
      prev_w     = w_out;
      prev_i     = w_index;
      prev_bv    = bv;
      stalled    = !rdy;
      @(negedge clk);
      cyc++;
      if (rdy) t++;
    end
    byte_valid = 1'b0;
    w_ready    = 1'b0;
    check("final_byte_drop", {31'b0, byte_drop}, {31'b0, prev_bv});
    check("valid_after_w63", {31'b0, w_valid}, 32'd0);
    check("sched_done_pulse", {31'b0, sched_done}, 32'd1);
  endtask

  initial begin
    blk_t   abc, ff, rb;
    sched_t abc_w, exp_w;
    int     d0, dr0;

    abc   = abc_block();
    abc_w = ref_schedule(abc);
    for (int i = 0; i < 64; i++) ff[i] = 8'hFF;

    rst_n = 1'b0; byte_in = '0; byte_valid = 1'b0; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_w_out", w_out, 32'd0);
    check("rst_w_valid", {31'b0, w_valid}, 32'd0);
    check("rst_w_index", {26'b0, w_index}, 32'd0);
    check("rst_sched_done", {31'b0, sched_done}, 32'd0);
    check("rst_byte_drop", {31'b0, byte_drop}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain "abc" block with ready held high.
    send_block(abc, 0);
    receive_block(abc_w, 0, 1'b0);
    check("abc_W0", got_w[0], 32'h61626380);
    check("abc_W1", got_w[1], 32'h0);
    check("abc_W14", got_w[14], 32'h0);
    check("abc_W15", got_w[15], 32'h00000018);
    check("abc_W16", got_w[16], 32'h61626380);
    check("abc_W17", got_w[17], 32'h000F0000);
    check("abc_W18", got_w[18], 32'h7DA86405);
    @(negedge clk);
    check("sched_done_one_pulse", {31'b0, sched_done}, 32'd0);
    check("done_count_1", 32'(done_cnt), 32'd1);

    // Toggling ready: identical sequence, stable while stalled.
    send_block(abc, 0);
    receive_block(abc_w, 1, 1'b0);
    @(negedge clk);

    // Five-cycle gaps between bytes.
    send_block(abc, 5);
    receive_block(abc_w, 0, 1'b0);
    check("gap_W0", got_w[0], 32'h61626380);
    @(negedge clk);

    // Bytes offered during EMIT at t=10 and in the W63 handshake cycle.
    dr0 = drop_cnt;
    send_block(abc, 0);
    receive_block(abc_w, 0, 1'b1);
    send_block(abc, 0);
    receive_block(abc_w, 0, 1'b0);
    check("drop_count", 32'(drop_cnt - dr0), 32'd2);
    check("post_drop_W0", got_w[0], 32'h61626380);
    @(negedge clk);

    // Reset after 30 bytes discards the partial block.
    d0 = done_cnt;
    for (int i = 0; i < 30; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_w_out", w_out, 32'd0);
    check("midrst_w_valid", {31'b0, w_valid}, 32'd0);
    check("midrst_w_index", {26'b0, w_index}, 32'd0);
    @(negedge clk);
    check("midrst_sched_done", {31'b0, sched_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_block(abc, 0);
    receive_block(abc_w, 0, 1'b0);
    @(negedge clk);
    check("reset_done_count", 32'(done_cnt - d0), 32'd1);

    // Back-to-back blocks; the second starts the cycle after the W63 handshake.
    d0 = done_cnt;
    send_block(abc, 0);
    receive_block(abc_w, 0, 1'b0);
    send_block(ff, 0);
    receive_block(ref_schedule(ff), 0, 1'b0);
    check("ff_W0", got_w[0], 32'hFFFFFFFF);
    @(negedge clk);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Random blocks with random gaps and random ready.
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 64; i++) rb[i] = 8'($urandom);
      exp_w = ref_schedule(rb);
      send_block(rb, int'($urandom_range(0, 2)));
      receive_block(exp_w, 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
